// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: synchronises and edge-detects external lines, latches pending bits,
// picks a fixed-priority winner and runs a non-nesting irq_req/irq_ack/mret handshake.
module interrupt_arbiter #(
    parameter int WIDTH     = 32,
    parameter int INT_WIDTH = 8,
    localparam int CAUSE_W  = $clog2(INT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INT_WIDTH-1:0] int_in,
    input  logic [INT_WIDTH-1:0] int_en,
    input  logic                 glb_ie,
    input  logic [WIDTH-1:0]     mtvec,
    input  logic [WIDTH-1:0]     pc_in,
    input  logic                 instr_done,
    input  logic                 irq_ack,
    input  logic                 mret,
    output logic                 irq_req,
    output logic [WIDTH-1:0]     trap_pc,
    output logic [WIDTH-1:0]     epc,
    output logic [CAUSE_W-1:0]   cause,
    output logic                 in_service,
    output logic [INT_WIDTH-1:0] pending
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                 state, state_next;
    logic [INT_WIDTH-1:0]   s1, s2, s3;
    logic [INT_WIDTH-1:0]   rise, elig, clr;
    logic [CAUSE_W-1:0]     winner;
    logic                   take;
    logic [WIDTH-1:0]       vector_base;
    logic [WIDTH-1:0]       vector_offset;

    assign rise          = s2 & ~s3;
    assign elig          = pending & int_en;
    assign vector_base   = mtvec & ~WIDTH'(3);
    assign vector_offset = {{(WIDTH-CAUSE_W-2){1'b0}}, winner, 2'b00};
    assign irq_req       = (state == REQ);
    assign in_service    = (state == SERVICE);

    // Descending scan so the lowest-index eligible line is the last to overwrite the winner.
    always_comb begin
        winner = '0;
        for (int i = INT_WIDTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        clr        = '0;
        case (state)
            IDLE: begin
                if (glb_ie && (|elig) && instr_done) begin
                    state_next = REQ;
                    take       = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_next = SERVICE;
                    clr[cause] = 1'b1;
                end
            end
            SERVICE: begin
                if (mret) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rising edge landing on the same cycle as the clear keeps the bit pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            pending <= '0;
        end else begin
            s1      <= int_in;
            s2      <= s1;
            s3      <= s2;
            pending <= (pending & ~clr) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cause   <= '0;
            epc     <= '0;
            trap_pc <= '0;
        end else if (take) begin
            cause   <= winner;
            epc     <= pc_in;
            trap_pc <= vector_base + vector_offset;
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_interrupt_arbiter;

    localparam int WIDTH     = 32;
    localparam int INT_WIDTH = 8;
    localparam int CAUSE_W   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [INT_WIDTH-1:0] int_in;
    logic [INT_WIDTH-1:0] int_en;
    logic                 glb_ie;
    logic [WIDTH-1:0]     mtvec;
    logic [WIDTH-1:0]     pc_in;
    logic                 instr_done;
    logic                 irq_ack;
    logic                 mret;
    logic                 irq_req;
    logic [WIDTH-1:0]     trap_pc;
    logic [WIDTH-1:0]     epc;
    logic [CAUSE_W-1:0]   cause;
    logic                 in_service;
    logic [INT_WIDTH-1:0] pending;

    int checks = 0;
    int errors = 0;

    // Model state: raw samples of int_in (newest first) and the architectural view.
    logic [INT_WIDTH-1:0] hist[$];
    logic [INT_WIDTH-1:0] m_pending;
    logic                 m_req;
    logic                 m_svc;
    logic [CAUSE_W-1:0]   m_cause;
    logic [WIDTH-1:0]     m_epc;
    logic [WIDTH-1:0]     m_trap;

    always #5 clk = ~clk;

    interrupt_arbiter #(.WIDTH(WIDTH), .INT_WIDTH(INT_WIDTH)) dut (
        .clk(clk), .rst(rst), .int_in(int_in), .int_en(int_en), .glb_ie(glb_ie),
        .mtvec(mtvec), .pc_in(pc_in), .instr_done(instr_done), .irq_ack(irq_ack),
        .mret(mret), .irq_req(irq_req), .trap_pc(trap_pc), .epc(epc), .cause(cause),
        .in_service(in_service), .pending(pending)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist = {8'h00, 8'h00, 8'h00, 8'h00};
        m_pending = '0;
        m_req     = 1'b0;
        m_svc     = 1'b0;
        m_cause   = '0;
        m_epc     = '0;
        m_trap    = '0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare #1 later.
    task automatic tick();
        logic [INT_WIDTH-1:0] elig, onehot, rise, clr;
        int win;
        elig   = m_pending & int_en;
        onehot = elig & (~elig + 8'd1);
        win    = $countones(onehot - 8'd1);
        clr    = '0;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            hist.push_front(int_in);
            void'(hist.pop_back());
            // An edge on int_in before edge e shows as pending at edge e+2.
            rise = hist[2] & ~hist[3];
            if (!m_req && !m_svc) begin
                if (glb_ie && elig != 0 && instr_done) begin
                    m_req   = 1'b1;
                    m_cause = CAUSE_W'(win);
                    m_epc   = pc_in;
                    m_trap  = (mtvec & 32'hFFFF_FFFC) + 32'(win * 4);
                end
            end else if (m_req) begin
                if (irq_ack) begin
                    m_req = 1'b0;
                    m_svc = 1'b1;
                    clr   = 8'd1 << m_cause;
                end
            end else if (mret) begin
                m_svc = 1'b0;
            end
            m_pending = (m_pending & ~clr) | rise;
        end
        #1;
        check_output("irq_req", irq_req, m_req);
        check_output("in_service", in_service, m_svc);
        check_output("pending", pending, m_pending);
        if (m_req || m_svc) begin
            check_output("cause", cause, m_cause);
            check_output("epc", epc, m_epc);
            check_output("trap_pc", trap_pc, m_trap);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req(input string tag);
        for (int n = 0; n < 20 && !irq_req; n++) tick();
        check_output(tag, irq_req, 1'b1);
    endtask

    task automatic apply_stimulus(input logic ack, input logic ret);
        irq_ack = ack;
        mret    = ret;
        tick();
        irq_ack = 1'b0;
        mret    = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        model_reset();
        rst = 1'b0; int_in = 8'hFF; int_en = 8'hFF; glb_ie = 1'b1; mtvec = 32'h100;
        pc_in = 32'h40; instr_done = 1'b1; irq_ack = 1'b0; mret = 1'b0;

        // Reset with all lines high, then release with lines quiet.
        #12;
        check_output("rst irq_req", irq_req, 1'b0);
        check_output("rst in_service", in_service, 1'b0);
        check_output("rst pending", pending, 8'h00);
        check_output("rst trap_pc", trap_pc, 32'h0);
        check_output("rst epc", epc, 32'h0);
        check_output("rst cause", cause, 3'd0);
        ticks(2);
        int_in = 8'h00;
        rst = 1'b1;
        ticks(6);

        // Single line 3 with exact latency.
        int_in = 8'h08;
        ticks(3);
        check_output("lat pending3", pending[3], 1'b1);
        check_output("lat no req yet", irq_req, 1'b0);
        tick();
        check_output("lat req", irq_req, 1'b1);
        check_output("single cause", cause, 3'd3);
        check_output("single trap_pc", trap_pc, 32'h10C);
        check_output("single epc", epc, 32'h40);
        apply_stimulus(1'b1, 1'b0);
        check_output("ack pending3", pending[3], 1'b0);
        check_output("ack in_service", in_service, 1'b1);
        apply_stimulus(1'b0, 1'b1);

        // Two lines together: line 1 first, then line 5.
        int_in = 8'h00; ticks(4);
        int_in = 8'h22;
        wait_req("prio wait1");
        check_output("prio cause1", cause, 3'd1);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        wait_req("prio wait5");
        check_output("prio cause5", cause, 3'd5);
        check_output("prio trap5", trap_pc, 32'h114);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1);

        // Masked line stays pending; global enable also blocks.
        int_in = 8'h00; ticks(4);
        int_en = 8'hF7;
        int_in = 8'h08; ticks(6);
        check_output("mask pending3", pending[3], 1'b1);
        check_output("mask no req", irq_req, 1'b0);
        glb_ie = 1'b0; int_en = 8'hFF; ticks(4);
        check_output("glb_ie no req", irq_req, 1'b0);
        glb_ie = 1'b1;
        wait_req("mask wait");
        check_output("mask cause", cause, 3'd3);

        // Line 3 re-rises exactly on the ack edge.
        int_in = 8'h00; ticks(3);
        int_in = 8'h08; ticks(2);
        apply_stimulus(1'b1, 1'b0);
        check_output("rerise pending3", pending[3], 1'b1);
        check_output("rerise in_service", in_service, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        wait_req("rerise wait");
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1);

        // Trap vector wraps around the address space.
        mtvec = 32'hFFFF_FFFC;
        int_in = 8'h00; ticks(4);
        int_in = 8'h04;
        wait_req("wrap wait");
        check_output("wrap cause", cause, 3'd2);
        check_output("wrap trap_pc", trap_pc, 32'h4);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1);

        // mret while idle does nothing.
        ticks(3);
        apply_stimulus(1'b0, 1'b1);
        check_output("idle mret req", irq_req, 1'b0);
        check_output("idle mret svc", in_service, 1'b0);

        // Asynchronous reset in the middle of a request.
        int_in = 8'h00; ticks(4);
        int_in = 8'h01;
        wait_req("arst wait");
        #2 rst = 1'b0;
        #1;
        check_output("arst irq_req", irq_req, 1'b0);
        check_output("arst pending", pending, 8'h00);
        check_output("arst in_service", in_service, 1'b0);
        model_reset();
        int_in = 8'h00;
        tick();
        rst = 1'b1;
        ticks(4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int_in     = int_in ^ 8'($urandom & $urandom & $urandom);
            int_en     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            glb_ie     = ($urandom_range(0, 7) != 0);
            instr_done = $urandom_range(0, 1) == 1;
            mtvec      = ($urandom_range(0, 15) == 0) ? $urandom : mtvec;
            pc_in      = $urandom;
            irq_ack    = ($urandom_range(0, 2) == 0);
            mret       = ($urandom_range(0, 3) == 0);
            tick();
        end
        irq_ack = 1'b0; mret = 1'b0;
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
